// File: rtl/quad_step_generator_if.sv
// Peripheral register bus: 16-bit address, 8-bit data, chip select with
// separate write/read strobes and a registered read-data return.
interface quad_step_generator_if;
  logic [15:0] addr;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  modport master (
    output addr, cs, wr, rd, data_in,
    input  data_out
  );

  modport slave (
    input  addr, cs, wr, rd, data_in,
    output data_out
  );
endinterface

// File: rtl/quad_step_generator.sv
// Bus-programmable quadrature step generator: emits TARGET Gray-coded A/B
// steps, forward or reverse, one every max(PERIOD,1) clocks.
module quad_step_generator (
  input  logic                 clk,
  input  logic                 rst_n,
  quad_step_generator_if.slave bus,
  output logic                 A,
  output logic                 B,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [15:0] period_q, period_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] steps_q, steps_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;
  logic [1:0]  ab_q, ab_d;
  logic [7:0]  data_out_q, data_out_d;

  logic        wr_en, rd_en, ctrl_wr;
  logic        start_req, abort_req, clr_req;
  logic        start_move, start_empty;
  logic        step_ev, last_step;
  logic [15:0] period_eff;
  logic [7:0]  rd_mux;

  assign wr_en     = bus.cs & bus.wr;
  assign rd_en     = bus.cs & bus.rd;
  assign ctrl_wr   = wr_en && (bus.addr == 16'h0004);
  // ABORT dominates START when both arrive in the same CTRL write.
  assign abort_req = ctrl_wr & bus.data_in[2];
  assign start_req = ctrl_wr & bus.data_in[0] & ~bus.data_in[2];
  assign clr_req   = ctrl_wr & bus.data_in[3];

  assign period_eff  = (period_q == 16'd0) ? 16'd1 : period_q;
  assign start_move  = (state_q == ST_IDLE) && start_req && (target_q != 16'd0);
  assign start_empty = (state_q == ST_IDLE) && start_req && (target_q == 16'd0);
  assign step_ev     = (state_q == ST_RUN) && !abort_req &&
                       (pcnt_q == period_eff - 16'd1);
  assign last_step   = step_ev && (remaining_q == 16'd1);

  function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic rev);
    logic [1:0] nxt;
    nxt = ab;
    case (ab)
      2'b00: nxt = rev ? 2'b10 : 2'b01;
      2'b01: nxt = rev ? 2'b00 : 2'b11;
      2'b11: nxt = rev ? 2'b01 : 2'b10;
      2'b10: nxt = rev ? 2'b11 : 2'b00;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_move) state_d = ST_RUN;
      ST_RUN:  if (abort_req || last_step) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    A    = ab_q[1];
    B    = ab_q[0];
    done = done_q;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      16'h0000: rd_mux = target_q[7:0];
      16'h0001: rd_mux = target_q[15:8];
      16'h0002: rd_mux = period_q[7:0];
      16'h0003: rd_mux = period_q[15:8];
      16'h0004: rd_mux = {5'b00000, dir_q, done_q, state_q == ST_RUN};
      16'h0005: rd_mux = steps_q[7:0];
      16'h0006: rd_mux = steps_q[15:8];
      default:  rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    target_d    = target_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    pcnt_d      = pcnt_q;
    steps_d     = steps_q;
    dir_d       = dir_q;
    done_d      = done_q;
    ab_d        = ab_q;
    data_out_d  = rd_en ? rd_mux : 8'h00;

    // Configuration is frozen for the duration of a move.
    if (wr_en && (state_q == ST_IDLE)) begin
      case (bus.addr)
        16'h0000: target_d[7:0]  = bus.data_in;
        16'h0001: target_d[15:8] = bus.data_in;
        16'h0002: period_d[7:0]  = bus.data_in;
        16'h0003: period_d[15:8] = bus.data_in;
        default: ;
      endcase
    end

    if (start_move) begin
      remaining_d = target_q;
      dir_d       = bus.data_in[1];
      pcnt_d      = 16'd0;
      steps_d     = 16'd0;
    end else if (start_empty) begin
      steps_d = 16'd0;
    end else if ((state_q == ST_RUN) && !abort_req) begin
      if (step_ev) begin
        ab_d        = next_phase(ab_q, dir_q);
        remaining_d = remaining_q - 16'd1;
        steps_d     = steps_q + 16'd1;
        pcnt_d      = 16'd0;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end

    // START's effect on done overrides a CLR_DONE in the same write.
    if (start_move) begin
      done_d = 1'b0;
    end else if (start_empty || last_step) begin
      done_d = 1'b1;
    end else if (clr_req) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q    <= 16'd0;
      period_q    <= 16'd0;
      remaining_q <= 16'd0;
      pcnt_q      <= 16'd0;
      steps_q     <= 16'd0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      ab_q        <= 2'b00;
      data_out_q  <= 8'h00;
    end else begin
      target_q    <= target_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      pcnt_q      <= pcnt_d;
      steps_q     <= steps_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      ab_q        <= ab_d;
      data_out_q  <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_quad_step_generator.sv
// Scoreboard bench for quad_step_generator: stimulus pushes expected steps and
// read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_quad_step_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A, B, busy, done;

  quad_step_generator_if bus_if();

  quad_step_generator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ab;
    int unsigned edge_n;
    bit          last;
  } step_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp;
  } rd_t;

  step_t step_q[$];
  rd_t   rd_q[$];

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int dec_cnt = 0;
  logic rd_seen = 1'b0;

  // Reference model state: position index along the quadrature cycle.
  int          mdl_pos = 0;
  logic [15:0] mdl_target = 0, mdl_period = 0, mdl_steps = 0;
  logic        mdl_done = 0, mdl_dir = 0;
  int unsigned last_n = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_seen <= bus_if.cs & bus_if.rd;

  function automatic logic [1:0] gray(input int idx);
    int m;
    logic [1:0] r;
    m = ((idx % 4) + 4) % 4;
    case (m)
      0: r = 2'b00;
      1: r = 2'b01;
      2: r = 2'b11;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  function automatic int gidx(input logic [1:0] ab);
    int r;
    case (ab)
      2'b00: r = 0;
      2'b01: r = 1;
      2'b11: r = 2;
      default: r = 3;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares A/B steps and read data as the DUT presents them.
  initial begin : monitor
    logic [1:0] prev_ab;
    step_t s;
    rd_t r;
    prev_ab = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ab = {A, B};
        step_q.delete();
      end else begin
        if ({A, B} != prev_ab) begin
          if (gidx({A, B}) == ((gidx(prev_ab) + 1) % 4)) dec_cnt++;
          else dec_cnt--;
          if (step_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL step_unexpected actual=%b required=no change (cycle %0d)", {A, B}, cyc);
          end else begin
            s = step_q.pop_front();
            $display("step ab=%b edge=%0d exp_edge=%0d", {A, B}, cyc, s.edge_n);
            chk("step_ab", 32'({A, B}), 32'(s.ab));
            chk("step_edge", cyc, s.edge_n);
            if (s.last) begin
              chk("busy_at_last_step", 32'(busy), 32'd0);
              chk("done_at_last_step", 32'(done), 32'd1);
            end
          end
        end
        prev_ab = {A, B};
        if (rd_seen) begin
          if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL read_unexpected actual=0x%0h required=no read", bus_if.data_out);
          end else begin
            r = rd_q.pop_front();
            $display("read addr=0x%04h data=0x%02h exp=0x%02h", r.addr, bus_if.data_out, r.exp);
            chk($sformatf("read_0x%04h", r.addr), 32'(bus_if.data_out), 32'(r.exp));
          end
        end
      end
    end
  end

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    bus_if.addr = a;
    bus_if.data_in = d;
    bus_if.cs = 1'b1;
    bus_if.wr = 1'b1;
    @(negedge clk);
    bus_if.cs = 1'b0;
    bus_if.wr = 1'b0;
    $display("write addr=0x%04h data=0x%02h", a, d);
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [7:0] e);
    rd_t r;
    r.addr = a;
    r.exp = e;
    rd_q.push_back(r);
    bus_if.addr = a;
    bus_if.cs = 1'b1;
    bus_if.rd = 1'b1;
    @(negedge clk);
    bus_if.cs = 1'b0;
    bus_if.rd = 1'b0;
  endtask

  // Program and start a move; expect at most max_steps of its steps.
  task automatic do_move(input logic [15:0] t, input logic [15:0] p, input logic d,
                         input int max_steps);
    int pe, s, n_exp;
    step_t st;
    bus_wr(16'h0000, t[7:0]);
    bus_wr(16'h0001, t[15:8]);
    bus_wr(16'h0002, p[7:0]);
    bus_wr(16'h0003, p[15:8]);
    mdl_target = t;
    mdl_period = p;
    bus_wr(16'h0004, {6'b0, d, 1'b1});
    last_n = cyc;
    pe = (p == 0) ? 1 : int'(p);
    s = d ? -1 : 1;
    if (t != 0) begin
      n_exp = (int'(t) < max_steps) ? int'(t) : max_steps;
      for (int k = 1; k <= n_exp; k++) begin
        st.ab = gray(mdl_pos + s * k);
        st.edge_n = last_n + k * pe;
        st.last = (k == int'(t));
        step_q.push_back(st);
      end
      mdl_pos += s * n_exp;
      mdl_dir = d;
      mdl_steps = t;
      mdl_done = 1'b1;
      chk("busy_after_start", 32'(busy), 32'd1);
    end else begin
      mdl_done = 1'b1;
      mdl_steps = 0;
      chk("busy_empty_start", 32'(busy), 32'd0);
      chk("done_empty_start", 32'(done), 32'd1);
    end
  endtask

  task automatic finish_move(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL move_timeout actual=busy required=idle within %0d cycles", budget);
    end
    @(negedge clk);
    chk("steps_pending", 32'(step_q.size()), 32'd0);
    chk("done_after_move", 32'(done), 32'(mdl_done));
    bus_rd(16'h0004, {5'b0, mdl_dir, mdl_done, 1'b0});
    bus_rd(16'h0005, mdl_steps[7:0]);
    bus_rd(16'h0006, mdl_steps[15:8]);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int base;
    logic [15:0] t, p, a;
    logic d;
    bus_if.addr = 16'h0;
    bus_if.cs = 1'b0;
    bus_if.wr = 1'b0;
    bus_if.rd = 1'b0;
    bus_if.data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_A", 32'(A), 32'd0);
    chk("reset_B", 32'(B), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_data_out", 32'(bus_if.data_out), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i <= 7; i++) bus_rd(16'(i), 8'h00);
    bus_rd(16'hFFFF, 8'h00);
    @(negedge clk);
    chk("data_out_idle_zero", 32'(bus_if.data_out), 32'd0);

    // Forward 5 @ period 3, then reverse 4 @ period 0.
    do_move(16'd5, 16'd3, 1'b0, 1 << 30);
    finish_move(40);
    chk("phase_after_fwd", 32'({A, B}), 32'd1);
    do_move(16'd4, 16'd0, 1'b1, 1 << 30);
    finish_move(20);
    bus_rd(16'h0004, 8'h06);

    // Abort after 7 steps; ABORT+START must not start a move.
    do_move(16'd100, 16'd2, 1'b0, 7);
    while (cyc < last_n + 14) @(negedge clk);
    bus_wr(16'h0004, 8'h04);
    mdl_done = 1'b0;
    mdl_steps = 16'd7;
    chk("busy_after_abort", 32'(busy), 32'd0);
    chk("done_after_abort", 32'(done), 32'd0);
    bus_rd(16'h0005, 8'd7);
    bus_rd(16'h0004, 8'h00);
    bus_wr(16'h0004, 8'h05);
    chk("busy_abort_start", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    bus_rd(16'h0005, 8'd7);

    // Guard writes during a move are ignored.
    do_move(16'd6, 16'd2, 1'b1, 1 << 30);
    bus_wr(16'h0002, 8'h10);
    bus_wr(16'h0003, 8'h00);
    bus_wr(16'h0004, 8'h01);
    bus_rd(16'h0002, 8'h02);
    finish_move(40);
    bus_rd(16'h0002, 8'h02);

    // TARGET=0 start, then CLR_DONE.
    do_move(16'd0, 16'd5, 1'b0, 1 << 30);
    repeat (4) @(negedge clk);
    finish_move(5);
    bus_wr(16'h0004, 8'h08);
    mdl_done = 1'b0;
    bus_rd(16'h0004, {5'b0, mdl_dir, 1'b0, 1'b0});

    // Randomized moves with register readback.
    for (int i = 0; i < 8; i++) begin
      t = 16'($urandom_range(1, 20));
      p = 16'($urandom_range(0, 4));
      d = 1'($urandom_range(0, 1));
      do_move(t, p, d, 1 << 30);
      finish_move(int'(t) * 5 + 10);
      bus_rd(16'h0000, mdl_target[7:0]);
      bus_rd(16'h0003, mdl_period[15:8]);
      a = 16'($urandom_range(7, 65535));
      bus_rd(a, 8'h00);
    end

    // Loopback through a decoder model: +1000 then -400.
    base = dec_cnt;
    do_move(16'd1000, 16'd0, 1'b0, 1 << 30);
    finish_move(1100);
    do_move(16'd400, 16'd1, 1'b1, 1 << 30);
    finish_move(500);
    chk("loopback_count", 32'(dec_cnt - base), 32'd600);

    // Asynchronous reset mid-move.
    do_move(16'd50, 16'd1, 1'b0, 1 << 30);
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_A", 32'(A), 32'd0);
    chk("async_rst_B", 32'(B), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    mdl_pos = 0;
    bus_rd(16'h0004, 8'h00);
    bus_rd(16'h0000, 8'h00);
    bus_rd(16'h0001, 8'h00);
    bus_rd(16'h0005, 8'h00);

    @(negedge clk);
    @(negedge clk);
    chk("final_steps_pending", 32'(step_q.size()), 32'd0);
    chk("final_reads_pending", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
